// File: rtl/pipibibs_snd_pkg.sv
// Sound subsystem shared types.
// Shared-RAM arbiter state and grant encodings.
package pipibibs_snd_pkg;

  localparam int SHRAM_AW = 11;
  localparam int SHRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    ACK
  } shram_state_t;

  typedef enum logic {
    GNT_Z80 = 1'b0,
    GNT_68K = 1'b1
  } shram_gnt_t;

endpackage

// File: rtl/pipibibs_shram_port.sv
// Per-requester served/pending tracker.
// A level request held high is served once; low for a cycle re-arms it.
module pipibibs_shram_port (
  input  logic CLK96,
  input  logic RESET96_N,
  input  logic cs,
  input  logic done,
  output logic pending
);

  logic served;

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      served <= 1'b0;
    end else if (!cs) begin
      served <= 1'b0;
    end else if (done) begin
      served <= 1'b1;
    end
  end

  assign pending = cs & ~served;

endmodule

// File: rtl/pipibibs_shram_arbiter.sv
// Z80 / M68K arbiter for the 2 KB sound shared RAM.
// One access in flight; registered SRAM side and per-port read data.
module pipibibs_shram_arbiter
  import pipibibs_snd_pkg::*;
#(
  parameter int AW       = SHRAM_AW,
  parameter int DW       = SHRAM_DW,
  parameter int RD_LAT   = 1,
  parameter int Z80_PRIO = 1
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic          Z80_CS,
  input  logic          Z80_WE,
  input  logic [AW-1:0] Z80_ADDR,
  input  logic [DW-1:0] Z80_DIN,
  output logic [DW-1:0] Z80_DOUT,
  output logic          Z80_OK,
  input  logic          M68K_CS,
  input  logic          M68K_WE,
  input  logic [AW-1:0] M68K_ADDR,
  input  logic [DW-1:0] M68K_DIN,
  output logic [DW-1:0] M68K_DOUT,
  output logic          M68K_OK,
  output logic          M68K_WAIT,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [DW-1:0] SRAM_DIN,
  output logic          SRAM_WE,
  input  logic [DW-1:0] SRAM_DOUT
);

  shram_state_t  state, state_nxt;
  shram_gnt_t    gnt, win, last_grant;
  logic          we_q;
  logic [1:0]    cnt;
  logic          z_pend, m_pend;
  logic          z_done, m_done;
  logic          any_pend;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_din;

  pipibibs_shram_port u_z80_port (
    .CLK96     (CLK96),
    .RESET96_N (RESET96_N),
    .cs        (Z80_CS),
    .done      (z_done),
    .pending   (z_pend)
  );

  pipibibs_shram_port u_m68k_port (
    .CLK96     (CLK96),
    .RESET96_N (RESET96_N),
    .cs        (M68K_CS),
    .done      (m_done),
    .pending   (m_pend)
  );

  assign any_pend  = z_pend | m_pend;
  assign z_done    = (state == ACK) && (gnt == GNT_Z80);
  assign m_done    = (state == ACK) && (gnt == GNT_68K);
  assign M68K_WAIT = M68K_CS & m_pend & ~M68K_OK;

  always_comb begin
    win = GNT_Z80;
    if (z_pend && m_pend) begin
      if (Z80_PRIO == 0 && last_grant == GNT_Z80) begin
        win = GNT_68K;
      end
    end else if (m_pend) begin
      win = GNT_68K;
    end
    win_we   = (win == GNT_68K) ? M68K_WE   : Z80_WE;
    win_addr = (win == GNT_68K) ? M68K_ADDR : Z80_ADDR;
    win_din  = (win == GNT_68K) ? M68K_DIN  : Z80_DIN;
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_pend) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (we_q || RD_LAT <= 1) state_nxt = ACK;
        else                     state_nxt = RDWAIT;
      end
      RDWAIT: begin
        if (cnt <= 2'd1) state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write strobe is set on entry to ISSUE so it is high only in ISSUE.
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      SRAM_ADDR  <= '0;
      SRAM_DIN   <= '0;
      SRAM_WE    <= 1'b0;
      Z80_OK     <= 1'b0;
      M68K_OK    <= 1'b0;
      Z80_DOUT   <= '0;
      M68K_DOUT  <= '0;
      last_grant <= GNT_68K;
      gnt        <= GNT_Z80;
      we_q       <= 1'b0;
      cnt        <= '0;
    end else begin
      SRAM_WE <= 1'b0;
      Z80_OK  <= 1'b0;
      M68K_OK <= 1'b0;
      case (state)
        IDLE: begin
          if (any_pend) begin
            gnt       <= win;
            we_q      <= win_we;
            SRAM_ADDR <= win_addr;
            SRAM_DIN  <= win_din;
            SRAM_WE   <= win_we;
          end
        end
        ISSUE: begin
          cnt <= 2'(RD_LAT - 1);
        end
        RDWAIT: begin
          cnt <= cnt - 2'd1;
        end
        ACK: begin
          last_grant <= gnt;
          if (gnt == GNT_Z80) begin
            Z80_OK <= 1'b1;
            if (!we_q) Z80_DOUT <= SRAM_DOUT;
          end else begin
            M68K_OK <= 1'b1;
            if (!we_q) M68K_DOUT <= SRAM_DOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipibibs_shram_arbiter.sv
// Bench for the sound shared-RAM arbiter.
// Two instances: RD_LAT=1/Z80 priority and RD_LAT=3/round-robin.
module tb_pipibibs_shram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        z_cs   [2];
  logic        z_we   [2];
  logic [10:0] z_addr [2];
  logic [7:0]  z_din  [2];
  logic [7:0]  z_dout [2];
  logic        z_ok   [2];
  logic        m_cs   [2];
  logic        m_we   [2];
  logic [10:0] m_addr [2];
  logic [7:0]  m_din  [2];
  logic [7:0]  m_dout [2];
  logic        m_ok   [2];
  logic        m_wait [2];
  logic [10:0] s_addr [2];
  logic [7:0]  s_din  [2];
  logic        s_we   [2];
  logic [7:0]  s_dout [2];

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem  [2][2048];
  logic [7:0]  pipe [2][3];
  logic [7:0]  sh   [2][2048];
  bit          vld  [2][2048];

  int          we_cnt [2];
  int          ok_cnt [2];
  int          gcnt   [2];
  int          glog   [2][64];
  logic [10:0] last_wa [2];
  logic [7:0]  last_wd [2];

  logic [7:0]  r_rd [2];
  int          r_e  [2];
  bit          r_w  [2];
  bit          r_t  [2];

  pipibibs_shram_arbiter #(.RD_LAT(1), .Z80_PRIO(1)) u_a (
    .CLK96(clk), .RESET96_N(rst_n[0]),
    .Z80_CS(z_cs[0]), .Z80_WE(z_we[0]), .Z80_ADDR(z_addr[0]),
    .Z80_DIN(z_din[0]), .Z80_DOUT(z_dout[0]), .Z80_OK(z_ok[0]),
    .M68K_CS(m_cs[0]), .M68K_WE(m_we[0]), .M68K_ADDR(m_addr[0]),
    .M68K_DIN(m_din[0]), .M68K_DOUT(m_dout[0]), .M68K_OK(m_ok[0]),
    .M68K_WAIT(m_wait[0]),
    .SRAM_ADDR(s_addr[0]), .SRAM_DIN(s_din[0]),
    .SRAM_WE(s_we[0]), .SRAM_DOUT(s_dout[0])
  );

  pipibibs_shram_arbiter #(.RD_LAT(3), .Z80_PRIO(0)) u_b (
    .CLK96(clk), .RESET96_N(rst_n[1]),
    .Z80_CS(z_cs[1]), .Z80_WE(z_we[1]), .Z80_ADDR(z_addr[1]),
    .Z80_DIN(z_din[1]), .Z80_DOUT(z_dout[1]), .Z80_OK(z_ok[1]),
    .M68K_CS(m_cs[1]), .M68K_WE(m_we[1]), .M68K_ADDR(m_addr[1]),
    .M68K_DIN(m_din[1]), .M68K_DOUT(m_dout[1]), .M68K_OK(m_ok[1]),
    .M68K_WAIT(m_wait[1]),
    .SRAM_ADDR(s_addr[1]), .SRAM_DIN(s_din[1]),
    .SRAM_WE(s_we[1]), .SRAM_DOUT(s_dout[1])
  );

  // SRAM model: read data appears RD_LAT cycles after the address
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_we[i]) mem[i][s_addr[i]] <= s_din[i];
      pipe[i][0] <= mem[i][s_addr[i]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign s_dout[0] = pipe[0][0];
  assign s_dout[1] = pipe[1][2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_we[i]) begin
        we_cnt[i]  <= we_cnt[i] + 1;
        last_wa[i] <= s_addr[i];
        last_wd[i] <= s_din[i];
      end
      ok_cnt[i] <= ok_cnt[i] + int'(z_ok[i]) + int'(m_ok[i]);
      if (z_ok[i]) begin
        glog[i][gcnt[i] % 64] <= 0;
        gcnt[i] <= gcnt[i] + 1;
      end else if (m_ok[i]) begin
        glog[i][gcnt[i] % 64] <= 1;
        gcnt[i] <= gcnt[i] + 1;
      end
    end
  end

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] outs(input int i);
    return {z_dout[i], m_dout[i], z_ok[i], m_ok[i], m_wait[i],
            s_addr[i], s_din[i], s_we[i]};
  endfunction

  task automatic access(
    input  int          i,
    input  bit          p,
    input  bit          we,
    input  logic [10:0] a,
    input  logic [7:0]  d,
    input  int          drop_at,
    input  bit          hold,
    output logic [7:0]  rd,
    output int          edges,
    output bit          wait_ok,
    output bit          tmo
  );
    @(negedge clk);
    if (p) begin
      m_we[i] = we; m_addr[i] = a; m_din[i] = d; m_cs[i] = 1'b1;
    end else begin
      z_we[i] = we; z_addr[i] = a; z_din[i] = d; z_cs[i] = 1'b1;
    end
    edges = 0; wait_ok = 1'b1; tmo = 1'b1; rd = '0;
    for (int k = 0; k < 40 && tmo; k++) begin
      @(posedge clk); #1;
      edges++;
      if (drop_at == edges) begin
        if (p) m_cs[i] = 1'b0;
        else   z_cs[i] = 1'b0;
      end
      if (p ? m_ok[i] : z_ok[i]) begin
        tmo = 1'b0;
        rd  = p ? m_dout[i] : z_dout[i];
        if (p && m_wait[i]) wait_ok = 1'b0;
      end else if (p && m_cs[i] && !m_wait[i]) begin
        wait_ok = 1'b0;
      end
    end
    if (!hold) begin
      @(negedge clk);
      if (p) m_cs[i] = 1'b0;
      else   z_cs[i] = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] rd; int e; bit w, t; int b;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (outs(i) !== '0) begin
        fails++;
        $display("FAIL reset_outs%0d: got %h want 0", i, outs(i));
      end
    end
    @(negedge clk); rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    access(0, 1'b0, 1'b1, 11'h123, 8'h77, 0, 1'b0, rd, e, w, t);
    sh[0][11'h123] = 8'h77; vld[0][11'h123] = 1'b1;
    access(0, 1'b0, 1'b0, 11'h123, 8'h00, 0, 1'b0, rd, e, w, t);
    tests++;
    if (rd !== 8'h77) begin
      fails++;
      $display("FAIL reset_pre_rd: got %h want 77", rd);
    end
    @(negedge clk);
    z_we[0] = 1'b0; z_addr[0] = 11'h123; z_cs[0] = 1'b1;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    #1;
    tests++;
    if (outs(0) !== '0) begin
      fails++;
      $display("FAIL reset_mid: got %h want 0", outs(0));
    end
    @(posedge clk); #1;
    tests++;
    if (outs(0) !== '0) begin
      fails++;
      $display("FAIL reset_hold: got %h want 0", outs(0));
    end
    @(negedge clk);
    rst_n[0] = 1'b1; z_cs[0] = 1'b0;
    b = ok_cnt[0];
    repeat (6) @(negedge clk);
    #1;
    tests++;
    if (ok_cnt[0] !== b) begin
      fails++;
      $display("FAIL reset_no_ok: got %0d want %0d", ok_cnt[0], b);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd; int e; bit w, t; int b;
    for (int i = 0; i < 2; i++) begin
      b = we_cnt[i];
      access(i, 1'b0, 1'b1, 11'h012, 8'h5A, 0, 1'b0, rd, e, w, t);
      sh[i][11'h012] = 8'h5A; vld[i][11'h012] = 1'b1;
      tests++;
      if (t || e !== 3) begin
        fails++;
        $display("FAIL wr_lat%0d: got %0d want 3", i, e);
      end
      tests++;
      if (we_cnt[i] - b !== 1 || last_wa[i] !== 11'h012 ||
          last_wd[i] !== 8'h5A) begin
        fails++;
        $display("FAIL wr_bus%0d: got %0d/%h/%h want 1/012/5a",
                 i, we_cnt[i] - b, last_wa[i], last_wd[i]);
      end
      access(i, 1'b0, 1'b0, 11'h012, 8'h00, 0, 1'b0, rd, e, w, t);
      tests++;
      if (t || e !== 2 + lat(i) || rd !== 8'h5A) begin
        fails++;
        $display("FAIL rd%0d: got %0d/%h want %0d/5a",
                 i, e, rd, 2 + lat(i));
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] rd; int e; bit w, t; int g;
    access(0, 1'b0, 1'b1, 11'h7FF, 8'h3C, 0, 1'b0, rd, e, w, t);
    sh[0][11'h7FF] = 8'h3C;
    g = gcnt[0];
    fork
      access(0, 1'b0, 1'b0, 11'h7FF, 8'h00, 0, 1'b0,
             r_rd[0], r_e[0], r_w[0], r_t[0]);
      access(0, 1'b1, 1'b1, 11'h7FF, 8'hA5, 0, 1'b0,
             r_rd[1], r_e[1], r_w[1], r_t[1]);
    join
    sh[0][11'h7FF] = 8'hA5;
    tests++;
    if (r_t[0] || r_e[0] !== 3 || r_rd[0] !== 8'h3C) begin
      fails++;
      $display("FAIL prio_z80: got %0d/%h want 3/3c", r_e[0], r_rd[0]);
    end
    tests++;
    if (r_t[1] || r_e[1] !== 6) begin
      fails++;
      $display("FAIL prio_68k_lat: got %0d want 6", r_e[1]);
    end
    tests++;
    if (!r_w[1]) begin
      fails++;
      $display("FAIL prio_wait: got 0 want 1");
    end
    tests++;
    if (glog[0][g % 64] !== 0 || glog[0][(g + 1) % 64] !== 1) begin
      fails++;
      $display("FAIL prio_order: got %0d,%0d want 0,1",
               glog[0][g % 64], glog[0][(g + 1) % 64]);
    end
    access(0, 1'b1, 1'b0, 11'h7FF, 8'h00, 0, 1'b0, rd, e, w, t);
    tests++;
    if (t || e !== 3 || rd !== 8'hA5) begin
      fails++;
      $display("FAIL prio_readback: got %0d/%h want 3/a5", e, rd);
    end
  endtask

  task automatic test_hold();
    logic [7:0] rd; int e; bit w, t; int bo, bw;
    bo = ok_cnt[0]; bw = we_cnt[0];
    access(0, 1'b0, 1'b1, 11'h2AA, 8'h96, 0, 1'b1, rd, e, w, t);
    sh[0][11'h2AA] = 8'h96; vld[0][11'h2AA] = 1'b1;
    repeat (20) @(negedge clk);
    z_cs[0] = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (t || ok_cnt[0] - bo !== 1) begin
      fails++;
      $display("FAIL hold_ok: got %0d want 1", ok_cnt[0] - bo);
    end
    tests++;
    if (we_cnt[0] - bw !== 1) begin
      fails++;
      $display("FAIL hold_we: got %0d want 1", we_cnt[0] - bw);
    end
  endtask

  task automatic rr_one(input int i, input bit p, input int k);
    logic [10:0] a; logic [7:0] d, rd; bit we, w, t; int e;
    a  = (p ? 11'h200 : 11'h100) + 11'(k);
    we = 1'($urandom % 2);
    d  = 8'($urandom);
    if (!we && !vld[i][a]) we = 1'b1;
    access(i, p, we, a, d, 0, 1'b0, rd, e, w, t);
    tests++;
    if (t) begin
      fails++;
      $display("FAIL rr_tmo: got timeout want ok");
    end
    if (!we) begin
      tests++;
      if (rd !== sh[i][a]) begin
        fails++;
        $display("FAIL rr_rd: got %h want %h", rd, sh[i][a]);
      end
    end else begin
      sh[i][a] = d; vld[i][a] = 1'b1;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] rd; int e; bit w, t; int g; bit alt;
    @(negedge clk); rst_n[1] = 1'b0;
    @(negedge clk); rst_n[1] = 1'b1;
    g = gcnt[1];
    fork
      for (int k = 0; k < 4; k++) rr_one(1, 1'b0, k);
      for (int k = 0; k < 4; k++) rr_one(1, 1'b1, k);
    join
    alt = 1'b1;
    for (int j = 0; j < 8; j++)
      if (glog[1][(g + j) % 64] !== j % 2) alt = 1'b0;
    tests++;
    if (!alt || gcnt[1] - g !== 8) begin
      fails++;
      $display("FAIL rr_alt: got %0d grants alt=%0d want 8 alt=1",
               gcnt[1] - g, alt);
    end
    access(1, 1'b0, 1'b1, 11'h300, 8'h11, 0, 1'b0, rd, e, w, t);
    sh[1][11'h300] = 8'h11; vld[1][11'h300] = 1'b1;
    g = gcnt[1];
    fork
      access(1, 1'b0, 1'b0, 11'h300, 8'h00, 0, 1'b0,
             r_rd[0], r_e[0], r_w[0], r_t[0]);
      access(1, 1'b1, 1'b1, 11'h301, 8'h22, 0, 1'b0,
             r_rd[1], r_e[1], r_w[1], r_t[1]);
    join
    sh[1][11'h301] = 8'h22; vld[1][11'h301] = 1'b1;
    tests++;
    if (glog[1][g % 64] !== 1 || r_e[1] !== 3) begin
      fails++;
      $display("FAIL rr_68k_first: got %0d/%0d want 1/3",
               glog[1][g % 64], r_e[1]);
    end
    tests++;
    if (r_t[0] || r_rd[0] !== 8'h11) begin
      fails++;
      $display("FAIL rr_z80_rd: got %h want 11", r_rd[0]);
    end
  endtask

  task automatic test_midfall();
    logic [7:0] rd; int e; bit w, t; int b;
    access(1, 1'b0, 1'b1, 11'h044, 8'hC3, 0, 1'b0, rd, e, w, t);
    sh[1][11'h044] = 8'hC3; vld[1][11'h044] = 1'b1;
    access(1, 1'b1, 1'b0, 11'h044, 8'h00, 2, 1'b0, rd, e, w, t);
    tests++;
    if (t || e !== 5 || rd !== 8'hC3) begin
      fails++;
      $display("FAIL drop_rd: got %0d/%h want 5/c3", e, rd);
    end
    access(1, 1'b1, 1'b0, 11'h012, 8'h00, 0, 1'b0, rd, e, w, t);
    tests++;
    if (t || e !== 5 || rd !== 8'h5A) begin
      fails++;
      $display("FAIL drop_rearm: got %0d/%h want 5/5a", e, rd);
    end
    b = we_cnt[1];
    access(1, 1'b1, 1'b1, 11'h045, 8'h3E, 2, 1'b0, rd, e, w, t);
    sh[1][11'h045] = 8'h3E; vld[1][11'h045] = 1'b1;
    tests++;
    if (t || e !== 3 || we_cnt[1] - b !== 1) begin
      fails++;
      $display("FAIL drop_wr: got %0d/%0d want 3/1", e, we_cnt[1] - b);
    end
    access(1, 1'b0, 1'b0, 11'h045, 8'h00, 0, 1'b0, rd, e, w, t);
    tests++;
    if (t || rd !== 8'h3E) begin
      fails++;
      $display("FAIL drop_commit: got %h want 3e", rd);
    end
  endtask

  task automatic test_random(input int i);
    logic [10:0] a; logic [7:0] d, rd, oth; bit p, we, w, t; int e, b;
    for (int n = 0; n < 40; n++) begin
      p  = 1'($urandom % 2);
      we = 1'($urandom % 2);
      a  = 11'h400 + 11'($urandom % 16);
      d  = 8'($urandom);
      if (!we && !vld[i][a]) we = 1'b1;
      oth = p ? z_dout[i] : m_dout[i];
      b = we_cnt[i];
      access(i, p, we, a, d, 0, 1'b0, rd, e, w, t);
      tests++;
      if (t || e !== (we ? 3 : 2 + lat(i))) begin
        fails++;
        $display("FAIL rnd_lat%0d: got %0d want %0d",
                 i, e, we ? 3 : 2 + lat(i));
      end
      tests++;
      if (we_cnt[i] - b !== int'(we)) begin
        fails++;
        $display("FAIL rnd_we%0d: got %0d want %0d", i, we_cnt[i] - b, we);
      end
      tests++;
      if ((p ? z_dout[i] : m_dout[i]) !== oth) begin
        fails++;
        $display("FAIL rnd_other%0d: got %h want %h",
                 i, p ? z_dout[i] : m_dout[i], oth);
      end
      if (we) begin
        sh[i][a] = d; vld[i][a] = 1'b1;
      end else begin
        tests++;
        if (rd !== sh[i][a]) begin
          fails++;
          $display("FAIL rnd_rd%0d: got %h want %h", i, rd, sh[i][a]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      z_cs[i] = 1'b0; z_we[i] = 1'b0; z_addr[i] = '0; z_din[i] = '0;
      m_cs[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_din[i] = '0;
    end
    test_reset();
    test_write_read();
    test_priority();
    test_hold();
    test_round_robin();
    test_midfall();
    test_random(0);
    test_random(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
